// File: rtl/m_branch_target_buffer_pkg.sv
// Shared definitions for the fetch-stage branch target buffer: counter states,
// update actions and the PC index/tag split.
package m_branch_target_buffer_pkg;

  // Counter states for the default 2-bit predictor; wider counters use the functions below.
  localparam int STRONG_NT   = 0;
  localparam int WEAK_NT     = 1;
  localparam int WEAK_T      = 2;
  localparam int STRONG_T    = 3;
  localparam int WEAK_T_INIT = 2;

  typedef enum logic [1:0] {
    UP_NONE  = 2'd0,
    UP_ALLOC = 2'd1,
    UP_INC   = 2'd2,
    UP_DEC   = 2'd3
  } up_act_e;

  function automatic int f_strong_t(input int ctr_w);
    return (1 << ctr_w) - 1;
  endfunction

  function automatic int f_weak_t_init(input int ctr_w);
    return 1 << (ctr_w - 1);
  endfunction

  // pc[1:0] never participates: instructions are word aligned.
  function automatic logic [63:0] f_index(input logic [63:0] pc, input int index_w);
    logic [63:0] mask;
    mask = (64'd1 << index_w) - 64'd1;
    return (pc >> 2) & mask;
  endfunction

  function automatic logic [63:0] f_tag(input logic [63:0] pc, input int index_w);
    return pc >> (index_w + 2);
  endfunction

endpackage

// File: rtl/m_branch_target_buffer_if.sv
// Lookup, resolve/update and flush signals between the fetch logic and the BTB.
interface m_branch_target_buffer_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] w_lk_pc;
  logic              r_lk_hit;
  logic              r_lk_taken;
  logic [ADDR_W-1:0] r_lk_target;
  logic [ADDR_W-1:0] r_lk_pc;
  logic              w_up_valid;
  logic [ADDR_W-1:0] w_up_pc;
  logic              w_up_taken;
  logic [ADDR_W-1:0] w_up_target;
  logic              w_flush;
  logic [31:0]       r_hit_cnt;

  modport master (
    output w_lk_pc, w_up_valid, w_up_pc, w_up_taken, w_up_target, w_flush,
    input  r_lk_hit, r_lk_taken, r_lk_target, r_lk_pc, r_hit_cnt
  );

  modport slave (
    input  w_lk_pc, w_up_valid, w_up_pc, w_up_taken, w_up_target, w_flush,
    output r_lk_hit, r_lk_taken, r_lk_target, r_lk_pc, r_hit_cnt
  );
endinterface

// File: rtl/m_branch_target_buffer_sat_counter.sv
// Saturating up/down direction counter with synchronous load; never wraps.
module m_sat_counter #(
  parameter int CTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             load,
  input  logic [CTR_W-1:0] load_val,
  input  logic             inc,
  input  logic             dec,
  output logic [CTR_W-1:0] count
);
  localparam logic [CTR_W-1:0] CNT_MAX = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CNT_MIN = {CTR_W{1'b0}};
  localparam logic [CTR_W-1:0] CNT_ONE = CTR_W'(1);

  logic [CTR_W-1:0] count_nxt;

  // Next count: load wins, then clamped increment/decrement.
  always_comb begin
    count_nxt = count;
    if (load) begin
      count_nxt = load_val;
    end else if (inc && (count != CNT_MAX)) begin
      count_nxt = count + CNT_ONE;
    end else if (dec && (count != CNT_MIN)) begin
      count_nxt = count - CNT_ONE;
    end else begin
      count_nxt = count;
    end
  end

  // Counter register with synchronous reset and clock enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= CNT_MIN;
    end else if (ce) begin
      count <= count_nxt;
    end else begin
      count <= count;
    end
  end
endmodule

// File: rtl/m_branch_target_buffer.sv
// Direct-mapped tagged branch target buffer with per-entry saturating direction
// counters; one-cycle lookup aligned with the instruction-memory read.
module m_branch_target_buffer
  import m_branch_target_buffer_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int ADDR_W  = 32,
  parameter int CTR_W   = 2
) (
  input logic                       w_clk,
  input logic                       w_rst_n,
  input logic                       w_ce,
  m_branch_target_buffer_if.slave   bus
);
  localparam int INDEX_W = $clog2(ENTRIES);
  localparam int TAG_W   = ADDR_W - 2 - INDEX_W;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(f_weak_t_init(CTR_W));

  logic [ENTRIES-1:0]              valid;
  logic [ENTRIES-1:0][CTR_W-1:0]   ctr;
  logic [TAG_W-1:0]                tag_mem    [ENTRIES];
  logic [ADDR_W-1:0]               target_mem [ENTRIES];

  logic [INDEX_W-1:0] lk_idx;
  logic [TAG_W-1:0]   lk_tag;
  logic [INDEX_W-1:0] up_idx;
  logic [TAG_W-1:0]   up_tag;
  logic               lk_hit_nxt;
  logic               lk_taken_nxt;
  logic [ADDR_W-1:0]  lk_target_nxt;
  logic               up_hit;
  up_act_e            up_act;
  logic               mem_we;

  logic               lk_hit;
  logic               lk_taken;
  logic [ADDR_W-1:0]  lk_target;
  logic [ADDR_W-1:0]  lk_pc;
  logic [31:0]        hit_cnt;

  assign lk_idx = INDEX_W'(f_index(64'(bus.w_lk_pc), INDEX_W));
  assign lk_tag = TAG_W'(f_tag(64'(bus.w_lk_pc), INDEX_W));
  assign up_idx = INDEX_W'(f_index(64'(bus.w_up_pc), INDEX_W));
  assign up_tag = TAG_W'(f_tag(64'(bus.w_up_pc), INDEX_W));

  // Lookup and update-hit evaluation against the pre-edge state.
  always_comb begin
    lk_hit_nxt    = 1'b0;
    lk_taken_nxt  = 1'b0;
    lk_target_nxt = '0;
    up_hit        = 1'b0;
    if (valid[lk_idx] && (tag_mem[lk_idx] == lk_tag)) begin
      lk_hit_nxt    = 1'b1;
      lk_taken_nxt  = ctr[lk_idx][CTR_W-1];
      lk_target_nxt = target_mem[lk_idx];
    end else begin
      lk_hit_nxt    = 1'b0;
    end
    if (valid[up_idx] && (tag_mem[up_idx] == up_tag)) begin
      up_hit = 1'b1;
    end else begin
      up_hit = 1'b0;
    end
  end

  // A flush drops any update resolved in the same cycle.
  always_comb begin
    up_act = UP_NONE;
    if (bus.w_up_valid && !bus.w_flush) begin
      if (up_hit) begin
        if (bus.w_up_taken) begin
          up_act = UP_INC;
        end else begin
          up_act = UP_DEC;
        end
      end else begin
        if (bus.w_up_taken) begin
          up_act = UP_ALLOC;
        end else begin
          up_act = UP_NONE;
        end
      end
    end else begin
      up_act = UP_NONE;
    end
  end

  assign mem_we = w_rst_n && w_ce && ((up_act == UP_ALLOC) || (up_act == UP_INC));

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
    m_sat_counter #(.CTR_W(CTR_W)) u_ctr (
      .clk      (w_clk),
      .rst_n    (w_rst_n),
      .ce       (w_ce),
      .load     ((up_act == UP_ALLOC) && (up_idx == INDEX_W'(i))),
      .load_val (CTR_INIT),
      .inc      ((up_act == UP_INC) && (up_idx == INDEX_W'(i))),
      .dec      ((up_act == UP_DEC) && (up_idx == INDEX_W'(i))),
      .count    (ctr[i])
    );
  end

  // Valid bits: cleared by reset or flush, set on allocation.
  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      valid <= '0;
    end else if (w_ce) begin
      if (bus.w_flush) begin
        valid <= '0;
      end else if (up_act == UP_ALLOC) begin
        valid[up_idx] <= 1'b1;
      end else begin
        valid <= valid;
      end
    end else begin
      valid <= valid;
    end
  end

  // Tag/target storage left unreset so it maps onto RAM.
  always_ff @(posedge w_clk) begin
    if (mem_we) begin
      tag_mem[up_idx]    <= up_tag;
      target_mem[up_idx] <= bus.w_up_target;
    end
  end

  // Registered lookup result and hit counter.
  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      lk_hit    <= 1'b0;
      lk_taken  <= 1'b0;
      lk_target <= '0;
      lk_pc     <= '0;
      hit_cnt   <= 32'd0;
    end else if (w_ce) begin
      lk_hit    <= lk_hit_nxt;
      lk_taken  <= lk_taken_nxt;
      lk_target <= lk_target_nxt;
      lk_pc     <= bus.w_lk_pc;
      hit_cnt   <= lk_hit_nxt ? (hit_cnt + 32'd1) : hit_cnt;
    end else begin
      lk_hit    <= lk_hit;
      lk_taken  <= lk_taken;
      lk_target <= lk_target;
      lk_pc     <= lk_pc;
      hit_cnt   <= hit_cnt;
    end
  end

  assign bus.r_lk_hit    = lk_hit;
  assign bus.r_lk_taken  = lk_taken;
  assign bus.r_lk_target = lk_target;
  assign bus.r_lk_pc     = lk_pc;
  assign bus.r_hit_cnt   = hit_cnt;
endmodule

// File: doc/m_branch_target_buffer.md
Name: m_branch_target_buffer

Overview:
- Parametrised branch target buffer and direction predictor for the IF stage of the 5-stage pipeline.
- Generalises the fetch-side "memorised branch destination" scheme:
  - direct-mapped, tagged, valid-qualified entries;
  - saturating direction counters;
  - explicit resolve/update port driven from the branch-resolving stage;
  - single-cycle flush.
- Lookup latency is one cycle, which matches instruction-memory read latency so the prediction aligns with the fetched instruction.

Parameters:
- ENTRIES, 64, number of entries; power of two, at least 2.
- ADDR_W, 32, PC and target width.
- CTR_W, 2, saturating counter width; predict taken when MSB=1.
- INDEX_W, log2(ENTRIES), derived, not overridable.
- TAG_W, ADDR_W-2-INDEX_W, derived, full tag with no aliasing beyond index.

Ports:
- w_clk  in  1  clock; all state updates on posedge.
- w_rst_n  in  1  reset; synchronous, active-low.
- w_ce  in  1  clock enable; low freezes all state and outputs.
- w_lk_pc  in  ADDR_W  fetch PC to look up.
- r_lk_hit  out  1  registered: valid entry with matching tag.
- r_lk_taken  out  1  registered: r_lk_hit AND counter MSB.
- r_lk_target  out  ADDR_W  registered: stored target; 0 when r_lk_hit=0.
- r_lk_pc  out  ADDR_W  registered echo of w_lk_pc.
- w_up_valid  in  1  resolved conditional branch this cycle.
- w_up_pc  in  ADDR_W  PC of the resolved branch.
- w_up_taken  in  1  actual outcome.
- w_up_target  in  ADDR_W  actual taken destination.
- w_flush  in  1  invalidate all entries.
- r_hit_cnt  out  32  lookups that hit; wraps at 2^32.

Behaviour:
- Address split:
  - index = pc[INDEX_W+1:2];
  - tag = pc[ADDR_W-1:INDEX_W+2];
  - pc[1:0] is ignored.
- Storage per entry:
  - valid bit and counter are in flops, resettable;
  - tag and target are array storage, not reset.
- Reset (w_rst_n=0 at posedge):
  - all valid bits cleared, all counters cleared;
  - all registered outputs and r_hit_cnt set to 0;
  - takes effect regardless of w_ce.
- When w_ce=1 and not in reset, on each posedge:
  - Lookup: outputs take the result for w_lk_pc against the state as it was before this edge. A same-cycle update is not visible until the following lookup.
  - r_hit_cnt increments by 1 when the new r_lk_hit=1.
  - Update (when w_up_valid=1), with entry e = index(w_up_pc):
    - Miss (e invalid or tag differs) and taken: allocate. Set valid=1, tag, target=w_up_target, counter = 2^(CTR_W-1) (weakly taken). Any victim at that index is replaced.
    - Miss and not taken: no change (no allocation on not-taken).
    - Hit and taken: counter = min(counter+1, 2^CTR_W-1); target = w_up_target.
    - Hit and not taken: counter = max(counter-1, 0). Entry stays valid.
  - Flush: all valid bits cleared. Priority order is flush > update (a same-cycle update is dropped). The lookup result registered on the flush edge still uses pre-flush state.
- When w_ce=0: no state change of any kind, including r_hit_cnt.
- Combinational paths: none from inputs to outputs; every output comes straight from a flop.
- Counter arithmetic must not wrap: saturate at both ends.

Decomposition:
- Shared package holds:
  - counter-state constants (STRONG_NT=0 … STRONG_T=2^CTR_W-1, WEAK_T_INIT=2^(CTR_W-1));
  - index/tag extraction functions parameterised by INDEX_W.
- One sub-module: m_sat_counter, a CTR_W-bit saturating up/down counter with synchronous load. Instantiated per entry, or used as a function on the selected entry.
- Tag/target arrays stay inline so they infer RAM.

Test Plan (ENTRIES=64, CTR_W=2):
- Reset, then lookup 0x100: r_lk_hit=0, r_lk_taken=0, r_lk_target=0, r_hit_cnt=0.
- Update pc=0x100, taken, target=0x40; next-cycle lookup 0x100: hit=1, taken=1, target=0x40, r_hit_cnt=1. Lookup 0x200 (same index 0, different tag): hit=0.
- Two not-taken updates on 0x100 (counter 2→1→0); lookup: hit=1, taken=0. A third not-taken keeps counter at 0. Then one taken update gives counter 1, so taken=0.
- Four taken updates on 0x104 with target 0x80 (counter saturates at 3), then one not-taken; lookup: taken=1 (counter 2), target=0x80.
- Same-cycle lookup and allocate on 0x108: that lookup returns hit=0, the following lookup returns hit=1. Flush asserted together with an update to 0x10C: all subsequent lookups miss and 0x10C is not allocated.
- w_ce=0 held for 3 cycles while driving an update and a changing w_lk_pc: outputs and r_hit_cnt hold. Assert w_rst_n=0 mid-operation with w_ce=0: all outputs go to 0 on that edge.
